// File: rtl/ffs_reg.sv
// ffs_reg: registered find-first-set / find-last-set encoder for a 2**WIDTH_LOG-bit bitmap.
//
// Each cycle the sampled vector x is encoded by two balanced binary-tree priority encoders
// (one low-first, one high-first) and the results are registered with a fixed 1-cycle latency.
// Output registers load every cycle; out_valid is simply the registered in_valid.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   qualifies x for the current cycle
//   x          in   WIDTH-bit bitmap, bit 0 is the LSB
//   out_valid  out  registered in_valid
//   lsb        out  index of lowest set bit (0 when x is all-zero)
//   msb        out  index of highest set bit (0 when x is all-zero)
//   zero       out  high when x has no bit set
module ffs_reg #(
  parameter int unsigned WIDTH_LOG = 4,
  // Derived; do not override.
  localparam int unsigned WIDTH = 2 ** WIDTH_LOG
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     x,
  output logic                 out_valid,
  output logic [WIDTH_LOG-1:0] lsb,
  output logic [WIDTH_LOG-1:0] msb,
  output logic                 zero
);

  // Tree storage: level 0 holds the leaves, level WIDTH_LOG holds the single root.
  // Level l has WIDTH >> l live nodes; the remaining slots are tied to zero so every
  // element is driven. Each node's index is local to the span of 2**l bits it covers.
  logic [WIDTH-1:0]     w_any    [WIDTH_LOG+1];
  logic [WIDTH_LOG-1:0] w_lo_idx [WIDTH_LOG+1][WIDTH];
  logic [WIDTH_LOG-1:0] w_hi_idx [WIDTH_LOG+1][WIDTH];

  // Leaves: any-set is the bit itself, local index is always 0.
  assign w_any[0] = x;
  for (genvar j = 0; j < WIDTH; j++) begin : g_leaf
    assign w_lo_idx[0][j] = '0;
    assign w_hi_idx[0][j] = '0;
  end

  for (genvar l = 1; l <= WIDTH_LOG; l++) begin : g_lvl
    // Choosing the upper child adds the size of the lower child's span to its local index.
    localparam logic [WIDTH_LOG-1:0] HalfBit = WIDTH_LOG'(1) << (l - 1);
    localparam int unsigned Nodes = WIDTH >> l;

    for (genvar j = 0; j < WIDTH; j++) begin : g_node
      if (j < Nodes) begin : g_live
        logic w_lo_any;
        logic w_up_any;

        assign w_lo_any = w_any[l-1][2*j];
        assign w_up_any = w_any[l-1][2*j+1];

        assign w_any[l][j] = w_lo_any | w_up_any;

        // Low-first: prefer the lower half whenever it has any bit set.
        assign w_lo_idx[l][j] = w_lo_any ? w_lo_idx[l-1][2*j]
                                         : (w_lo_idx[l-1][2*j+1] | HalfBit);

        // High-first: prefer the upper half whenever it has any bit set.
        assign w_hi_idx[l][j] = w_up_any ? (w_hi_idx[l-1][2*j+1] | HalfBit)
                                         : w_hi_idx[l-1][2*j];
      end else begin : g_tie
        assign w_any[l][j]    = 1'b0;
        assign w_lo_idx[l][j] = '0;
        assign w_hi_idx[l][j] = '0;
      end
    end
  end

  logic                 w_zero;
  logic [WIDTH_LOG-1:0] w_lsb;
  logic [WIDTH_LOG-1:0] w_msb;

  assign w_zero = ~w_any[WIDTH_LOG][0];

  // With no bit set the tree would fall through to WIDTH-1 on the low side; force both to 0.
  assign w_lsb = w_zero ? '0 : w_lo_idx[WIDTH_LOG][0];
  assign w_msb = w_zero ? '0 : w_hi_idx[WIDTH_LOG][0];

  logic                 r_valid;
  logic                 r_zero;
  logic [WIDTH_LOG-1:0] r_lsb;
  logic [WIDTH_LOG-1:0] r_msb;

  // Free-running output stage: loads every cycle regardless of in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_zero  <= 1'b1;
      r_lsb   <= '0;
      r_msb   <= '0;
    end else begin
      r_valid <= in_valid;
      r_zero  <= w_zero;
      r_lsb   <= w_lsb;
      r_msb   <= w_msb;
    end
  end

  assign out_valid = r_valid;
  assign zero      = r_zero;
  assign lsb       = r_lsb;
  assign msb       = r_msb;

endmodule

// File: tb/tb_ffs_reg.sv
// Self-checking bench for ffs_reg (WIDTH_LOG=4): directed test-plan vectors, streaming,
// asynchronous reset checks, then randomized vectors against a bit-scan reference model.
module tb_ffs_reg;

  localparam int unsigned WL = 4;
  localparam int unsigned W  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  x = '0;
  logic          out_valid;
  logic [WL-1:0] lsb;
  logic [WL-1:0] msb;
  logic          zero;

  int n_cmp = 0;
  int n_err = 0;

  ffs_reg #(.WIDTH_LOG(WL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .x        (x),
    .out_valid(out_valid),
    .lsb      (lsb),
    .msb      (msb),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  // Reference model: plain scans over the bits.
  function automatic int ref_lsb(input logic [W-1:0] v);
    for (int i = 0; i < W; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int ref_msb(input logic [W-1:0] v);
    for (int i = W - 1; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, ".zero"},  {31'd0, zero},      32'd1);
    check({tag, ".lsb"},   {28'd0, lsb},       32'd0);
    check({tag, ".msb"},   {28'd0, msb},       32'd0);
  endtask

  // Present v for one edge, then check the registered result just after that edge.
  task automatic apply(input string tag, input logic [W-1:0] v, input logic vld);
    @(negedge clk);
    x        = v;
    in_valid = vld;
    @(posedge clk);
    #1;
    check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, vld});
    check({tag, ".zero"},  {31'd0, zero},      (v == '0) ? 32'd1 : 32'd0);
    check({tag, ".lsb"},   {28'd0, lsb},       32'(ref_lsb(v)));
    check({tag, ".msb"},   {28'd0, msb},       32'(ref_msb(v)));
  endtask

  initial begin
    logic [W-1:0] v;
    int           mode;

    // Power-on reset (explicit falling edge so the async reset fires).
    #2 rst_n = 1'b0;
    #1 check_reset("por");
    repeat (2) @(posedge clk);
    #1 check_reset("por_held");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed test-plan vectors.
    apply("all_zero", 16'h0000, 1'b1);
    apply("bit0",     16'h0001, 1'b1);
    apply("bit15",    16'h8000, 1'b1);
    apply("all_ones", 16'hFFFF, 1'b1);
    apply("pattern",  16'b0011100010101010, 1'b1);

    // Streaming on consecutive edges.
    apply("stream0", 16'h0100, 1'b1);
    apply("stream1", 16'h0006, 1'b1);

    // Mid-cycle reset: outputs must clear immediately, and stay clear across an edge.
    #2 rst_n = 1'b0;
    #1 check_reset("mid_rst");
    @(posedge clk);
    #1 check_reset("mid_rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    apply("post_rst", 16'h0420, 1'b1);

    // Data path is free-running even when in_valid is low.
    apply("inv_data", 16'h1010, 1'b0);

    // Randomized vectors with a mix of densities.
    for (int n = 0; n < 200; n++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0: v = W'($urandom);
        1: v = W'(1) << $urandom_range(0, W - 1);
        2: v = W'($urandom & $urandom & $urandom);
        default: v = ($urandom_range(0, 1) == 0) ? '0 : ~(W'(1) << $urandom_range(0, W - 1));
      endcase
      apply("rand", v, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
